// File: rtl/spectrum_sequencer.sv
// spectrum_sequencer: collects NPOINT ADC samples into an FFT input frame,
// hands the frame to an external FFT engine, turns each result bin into a
// clamped bar height and publishes the bar set on a display frame boundary.
// Optional build macro SPECTRUM_L1MAG_EN selects the |re|+|im| magnitude;
// without it only |re| is used.
module spectrum_sequencer #(
    parameter int NPOINT   = 4,
    parameter int SAMPLE_W = 12,
    parameter int BAR_W    = 10,
    parameter int SHIFT    = 6,
    parameter int MAX_BAR  = 480
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       run,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    output logic                       fft_start,
    output logic [NPOINT*32-1:0]       fft_in,
    input  logic [NPOINT*32-1:0]       fft_out,
    input  logic                       fft_done,
    input  logic                       frame_done,
    output logic [NPOINT*BAR_W-1:0]    bars,
    output logic                       bars_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int IDX_W = (NPOINT > 1) ? $clog2(NPOINT) : 1;

    typedef enum logic [2:0] {IDLE, COLLECT, FFT_RUN, MAG, WAIT_FRAME} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NPOINT*32-1:0]      fft_in_q, fft_in_d;
    logic [NPOINT*32-1:0]      fbuf_q, fbuf_d;
    logic [NPOINT*BAR_W-1:0]   work_q, work_d;
    logic [NPOINT*BAR_W-1:0]   bars_q, bars_d;
    logic                      fft_start_q, fft_start_d;
    logic                      bars_valid_q, bars_valid_d;
    logic                      overrun_q, overrun_d;

    logic [31:0]               mag_word;
    logic                      last_idx;
    logic signed [15:0]        sample_ext;

    // Absolute value of a 16-bit signed value; -32768 saturates to 32767.
    function automatic logic [15:0] abs_sat(input logic [15:0] v);
        if (v == 16'h8000)
            return 16'h7FFF;
        else if (v[15])
            return ~v + 16'd1;
        else
            return v;
    endfunction

    // Shift the magnitude down and clamp it to the tallest displayable bar.
    function automatic logic [BAR_W-1:0] shift_clamp(input logic [15:0] m);
        logic [15:0] sh;
        sh = m >> SHIFT;
        if (32'(sh) > MAX_BAR)
            return BAR_W'(MAX_BAR);
        else
            return BAR_W'(sh);
    endfunction

`ifdef SPECTRUM_L1MAG_EN
    // L1 magnitude: sum of both saturated terms, saturated to 16 bits.
    function automatic logic [BAR_W-1:0] bar_of(input logic [31:0] w);
        logic [16:0] sum;
        logic [15:0] m;
        sum = {1'b0, abs_sat(w[31:16])} + {1'b0, abs_sat(w[15:0])};
        m   = sum[16] ? 16'hFFFF : sum[15:0];
        return shift_clamp(m);
    endfunction
`else
    // Real-part magnitude only; the imaginary half of the word is ignored.
    function automatic logic [BAR_W-1:0] bar_of(input logic [31:0] w);
        return shift_clamp(abs_sat(w[31:16]));
    endfunction
`endif

    assign mag_word   = fbuf_q[32*idx_q +: 32];
    assign last_idx   = (idx_q == IDX_W'(NPOINT-1));
    assign sample_ext = 16'(sample_in);

    assign fft_start  = fft_start_q;
    assign fft_in     = fft_in_q;
    assign bars       = bars_q;
    assign bars_valid = bars_valid_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

    // Next-state and datapath updates for the acquisition/publish sequence.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fft_in_d     = fft_in_q;
        fbuf_d       = fbuf_q;
        work_d       = work_q;
        bars_d       = bars_q;
        fft_start_d  = fft_start_q;
        bars_valid_d = 1'b0;
        // A strobe that arrives while not collecting is dropped and remembered.
        overrun_d    = overrun_q | (sample_valid & run & (state_q != COLLECT));

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = COLLECT;
                    idx_d   = '0;
                end
            end
            COLLECT: begin
                if (sample_valid) begin
                    fft_in_d[32*idx_q +: 32] = {sample_ext, 16'h0000};
                    idx_d = idx_q + 1'b1;
                    if (last_idx) begin
                        state_d     = FFT_RUN;
                        fft_start_d = 1'b1;
                        idx_d       = '0;
                    end
                end
            end
            FFT_RUN: begin
                if (fft_done) begin
                    fbuf_d      = fft_out;
                    fft_start_d = 1'b0;
                    state_d     = MAG;
                    idx_d       = '0;
                end
            end
            MAG: begin
                work_d[BAR_W*idx_q +: BAR_W] = bar_of(mag_word);
                idx_d = idx_q + 1'b1;
                if (last_idx) begin
                    state_d = WAIT_FRAME;
                    idx_d   = '0;
                end
            end
            WAIT_FRAME: begin
                if (frame_done) begin
                    bars_d       = work_q;
                    bars_valid_d = 1'b1;
                    state_d      = run ? COLLECT : IDLE;
                    idx_d        = '0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, buffers and registered outputs; reset discards any partial frame.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            fft_in_q     <= '0;
            fbuf_q       <= '0;
            work_q       <= '0;
            bars_q       <= '0;
            fft_start_q  <= 1'b0;
            bars_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fft_in_q     <= fft_in_d;
            fbuf_q       <= fbuf_d;
            work_q       <= work_d;
            bars_q       <= bars_d;
            fft_start_q  <= fft_start_d;
            bars_valid_q <= bars_valid_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule

// File: doc/spectrum_sequencer.md
SPECTRUM_SEQUENCER -- requirements
Module: spectrum_sequencer

Interface
REQ-001 Parameter NPOINT, default 4, meaning FFT size and bar count; power of two, 4..64.
REQ-002 Parameter SAMPLE_W, default 12, meaning signed ADC sample width, at most 16.
REQ-003 Parameter BAR_W, default 10, meaning bar-height width.
REQ-004 Parameter SHIFT, default 6, meaning magnitude right-shift before clamping.
REQ-005 Parameter MAX_BAR, default 480, meaning bar clamp value, at most 2^BAR_W-1.
REQ-006 Port clock, input, 1, meaning the only clock.
REQ-007 Port rst, input, 1, meaning asynchronous active-low reset.
REQ-008 Port run, input, 1, meaning enable continuous frame acquisition.
REQ-009 Port sample_in, input, SAMPLE_W, meaning two's-complement sample.
REQ-010 Port sample_valid, input, 1, meaning one-cycle strobe qualifying sample_in.
REQ-011 Port fft_start, output, 1, meaning level request to the FFT engine.
REQ-012 Port fft_in, output, NPOINT*32, meaning packed inputs, word k at bits [32k+31:32k], {re[15:0], im[15:0]}.
REQ-013 Port fft_out, input, NPOINT*32, meaning FFT results packed as fft_in.
REQ-014 Port fft_done, input, 1, meaning FFT result valid.
REQ-015 Port frame_done, input, 1, meaning display frame boundary pulse.
REQ-016 Port bars, output, NPOINT*BAR_W, meaning published bar heights, bar k at bits [BAR_W*k+BAR_W-1:BAR_W*k].
REQ-017 Port bars_valid, output, 1, meaning one-cycle pulse after bars update.
REQ-018 Port busy, output, 1, meaning high in every state except IDLE.
REQ-019 Port overrun, output, 1, meaning sticky flag for a dropped sample.

Function
REQ-020 The block SHALL use states IDLE, COLLECT, FFT_RUN, MAG and WAIT_FRAME, all transitions on the rising edge of clock.
REQ-021 IDLE SHALL move to COLLECT when run=1 and SHALL reset the sample index to 0.
REQ-022 COLLECT SHALL write word k of fft_in as {sign-extend16(sample_in), 16'h0000} on each sample_valid, where k is the index, and SHALL then increment the index.
REQ-023 COLLECT SHALL move to FFT_RUN on the edge that stores sample NPOINT-1; fft_start SHALL be 1 from the next cycle.
REQ-024 fft_start SHALL stay high throughout FFT_RUN and SHALL fall in the cycle after fft_done is sampled high; FFT_RUN then SHALL move to MAG.
REQ-025 fft_in SHALL remain stable from entry into FFT_RUN until the next COLLECT.
REQ-026 On the fft_done edge, fft_out SHALL be captured into an internal buffer.
REQ-027 MAG SHALL process one bin per cycle, bins 0..NPOINT-1, and last exactly NPOINT cycles.
REQ-028 Per bin, m=|re| SHALL be computed with -32768 saturating to 32767; bar=min(m>>SHIFT, MAX_BAR); the result SHALL go to a working buffer only.
REQ-029 After bin NPOINT-1, MAG SHALL move to WAIT_FRAME.
REQ-030 In WAIT_FRAME with frame_done=1, bars SHALL load the working buffer on that edge, and bars_valid SHALL be 1 for exactly the next cycle.
REQ-031 From the WAIT_FRAME exit, the next state SHALL be COLLECT if run=1, otherwise IDLE.
REQ-032 Deasserting run mid-frame SHALL NOT abort that frame.
REQ-033 sample_valid outside COLLECT while run=1 SHALL drop the sample and set overrun; overrun SHALL clear only on reset.
REQ-034 fft_done outside FFT_RUN and frame_done outside WAIT_FRAME SHALL be ignored.
REQ-035 A frame_done in the same cycle as the MAG-to-WAIT_FRAME transition SHALL be ignored.
REQ-036 Between publishes, bars SHALL hold its value.

Reset
REQ-037 With rst=0, asynchronously: state=IDLE, index=0, fft_start=0, fft_in=0, bars=0, bars_valid=0, busy=0, overrun=0, and the internal buffers =0.
REQ-038 Reset mid-operation SHALL discard the partial frame; after rst rises the block SHALL restart from IDLE.

Configuration
REQ-039 With SPECTRUM_L1MAG_EN defined, m SHALL be |re|+|im|, each term saturated as in REQ-028, the 17-bit sum saturated to 65535, then shifted and clamped.
REQ-040 Without SPECTRUM_L1MAG_EN, m SHALL be |re| only and im SHALL be ignored.

Verification
REQ-041 Reset check: assert rst=0 mid-COLLECT -> all outputs 0 immediately; the frame restarts at index 0.
REQ-042 Collect check: NPOINT=4, samples 100,200,300,400 -> fft_in words 0x00640000, 0x00C80000, 0x012C0000, 0x01900000; fft_start=1 one cycle after the fourth strobe.
REQ-043 Magnitude check: re = 0x7FC0, 0x8000, 0xFF00, 0x0140 -> bars 480, 480, 4, 5 after frame_done; bars_valid is high for one cycle.
REQ-044 Overrun check: a sample_valid during FFT_RUN -> overrun=1; fft_in is unchanged.
REQ-045 Frame-hold check: frame_done held low for 1000 cycles after MAG -> state WAIT_FRAME, bars unchanged; then pulse frame_done -> publish and return to COLLECT.
REQ-046 L1 magnitude check: with SPECTRUM_L1MAG_EN, re=-256, im=320 -> bar 9; without the macro -> bar 4.
